// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: walks an active-low column, debounces whole scan
// frames and latches the first new key press as a CPU-readable event.
module key_scan #(
  parameter int FREQ     = 100,
  parameter int DEBOUNCE = 2
) (
  input  logic        kpd_clk,
  input  logic        kpd_rst,
  output logic [3:0]  kpd_col,
  input  logic [3:0]  kpd_row,
  input  logic [31:0] kpd_addr,
  input  logic        kpd_re,
  output logic [31:0] kpd_rdata,
  output logic        kpd_irq
);

  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [1:0]  r_idx;
  logic [15:0] r_cnt;
  logic [15:0] r_frame;
  logic [15:0] r_prev;
  logic [15:0] r_deb;
  logic [3:0]  r_stable;
  logic [3:0]  r_code;
  logic        r_valid;
  logic        r_ovf;
  logic [31:0] r_rdata;

  logic        w_sample;
  logic        w_frameDone;
  logic        w_same;
  logic [4:0]  w_stableInc;
  logic        w_debUpdate;
  logic [15:0] w_frameNext;
  logic [15:0] w_newKeys;
  logic [3:0]  w_newIdx;
  logic        w_event;
  logic        w_statusRead;
  logic        w_unusedAddr;

  assign w_unusedAddr = ^{kpd_addr[31:3], kpd_addr[1:0]};

  assign w_sample     = (r_cnt == 16'd0);
  assign w_frameDone  = w_sample && (r_idx == 2'd3);
  assign w_same       = (w_frameNext == r_prev);
  assign w_stableInc  = {1'b0, r_stable} + 5'd1;
  assign w_debUpdate  = w_frameDone &&
                        ((DEBOUNCE == 1) || (w_same && (w_stableInc >= 5'(DEBOUNCE - 1))));
  assign w_newKeys    = w_frameNext & ~r_deb;
  assign w_event      = w_debUpdate && (|w_newKeys);
  assign w_statusRead = kpd_re && !kpd_addr[2];

  // Frame as it will look after this edge's column sample is merged in.
  always_comb begin
    w_frameNext = r_frame;
    w_frameNext[{r_idx, 2'b00} +: 4] = ~r_sync2;
  end

  // Lowest-numbered newly pressed key wins.
  always_comb begin
    w_newIdx = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (w_newKeys[k]) w_newIdx = 4'(k);
    end
  end

  always_ff @(posedge kpd_clk) begin
    if (kpd_rst) begin
      r_sync1 <= 4'd0;
      r_sync2 <= 4'd0;
      r_idx   <= 2'd0;
      r_cnt   <= 16'(FREQ);
      r_frame <= 16'd0;
    end else begin
      r_sync1 <= kpd_row;
      r_sync2 <= r_sync1;
      if (w_sample) begin
        r_frame <= w_frameNext;
        r_idx   <= r_idx + 2'd1;
        r_cnt   <= 16'(FREQ);
      end else begin
        r_cnt <= r_cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge kpd_clk) begin
    if (kpd_rst) begin
      r_prev   <= 16'd0;
      r_stable <= 4'd0;
      r_deb    <= 16'd0;
    end else begin
      if (w_frameDone) begin
        r_prev <= w_frameNext;
        if (!w_same) begin
          r_stable <= 4'd0;
        end else if (r_stable != 4'hF) begin
          r_stable <= r_stable + 4'd1;
        end
      end
      if (w_debUpdate) r_deb <= w_frameNext;
    end
  end

  // A STATUS read consumes the pending event, so a colliding event is latched fresh.
  always_ff @(posedge kpd_clk) begin
    if (kpd_rst) begin
      r_rdata <= 32'd0;
      r_code  <= 4'd0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (kpd_re) begin
        r_rdata <= kpd_addr[2] ? {16'd0, r_deb} : {24'd0, r_code, 2'b00, r_ovf, r_valid};
      end
      if (w_statusRead) begin
        r_valid <= 1'b0;
        r_ovf   <= 1'b0;
      end
      if (w_event) begin
        if (r_valid && !w_statusRead) begin
          r_ovf <= 1'b1;
        end else begin
          r_code  <= w_newIdx;
          r_valid <= 1'b1;
          r_ovf   <= 1'b0;
        end
      end
    end
  end

  assign kpd_col   = ~(4'b0001 << r_idx);
  assign kpd_rdata = r_rdata;
  assign kpd_irq   = r_valid;

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with FREQ=3, DEBOUNCE=2 (16-cycle frames) and a
// behavioural keypad that pulls rows low for pressed keys in the driven column.
module tb_key_scan;

  localparam int FREQ     = 3;
  localparam int DEBOUNCE = 2;

  logic        kpd_clk = 1'b0;
  logic        kpd_rst;
  logic [3:0]  kpd_col;
  logic [3:0]  kpd_row;
  logic [31:0] kpd_addr;
  logic        kpd_re;
  logic [31:0] kpd_rdata;
  logic        kpd_irq;
  logic [15:0] keys;

  int nChecks = 0;
  int nFails  = 0;

  always #5 kpd_clk = ~kpd_clk;

  always_comb begin
    kpd_row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (kpd_col[c] === 1'b0 && keys[c*4 + r]) kpd_row[r] = 1'b0;
      end
    end
  end

  key_scan #(.FREQ(FREQ), .DEBOUNCE(DEBOUNCE)) dut (
    .kpd_clk  (kpd_clk),
    .kpd_rst  (kpd_rst),
    .kpd_col  (kpd_col),
    .kpd_row  (kpd_row),
    .kpd_addr (kpd_addr),
    .kpd_re   (kpd_re),
    .kpd_rdata(kpd_rdata),
    .kpd_irq  (kpd_irq)
  );

  task automatic waitCycles(input int n);
    repeat (n) @(negedge kpd_clk);
  endtask

  // Upper address bits are junk on purpose; only bit 2 selects the register.
  task automatic readReg(input logic sel, output logic [31:0] data);
    kpd_addr = sel ? 32'h1000_000C : 32'h1000_0008;
    kpd_re   = 1'b1;
    @(negedge kpd_clk);
    kpd_re   = 1'b0;
    data     = kpd_rdata;
  endtask

  task automatic waitIrq(input int budget, output int cycles);
    cycles = 0;
    while (kpd_irq !== 1'b1 && cycles < budget) begin
      @(negedge kpd_clk);
      cycles++;
    end
  endtask

  task automatic test_reset_values;
    kpd_rst = 1'b1;
    waitCycles(3);
    kpd_rst = 1'b0;
    nChecks++;
    if (kpd_col !== 4'b1110) begin
      nFails++; $display("[TB] FAIL por_col: got %b expected %b", kpd_col, 4'b1110);
    end
    nChecks++;
    if (kpd_irq !== 1'b0) begin
      nFails++; $display("[TB] FAIL por_irq: got %b expected 0", kpd_irq);
    end
    nChecks++;
    if (kpd_rdata !== 32'h0) begin
      nFails++; $display("[TB] FAIL por_rdata: got %h expected 0", kpd_rdata);
    end
  endtask

  task automatic test_single_press;
    int cyc;
    logic [31:0] d;
    keys = 16'h0200;
    waitIrq(80, cyc);
    nChecks++;
    if (kpd_irq !== 1'b1 || cyc > 50) begin
      nFails++; $display("[TB] FAIL press_latency: irq=%b after %0d cycles, required 1 within 50", kpd_irq, cyc);
    end
    readReg(1'b0, d);
    nChecks++;
    if (d !== 32'h91) begin
      nFails++; $display("[TB] FAIL press_status: got %h expected %h", d, 32'h91);
    end
    nChecks++;
    if (kpd_irq !== 1'b0) begin
      nFails++; $display("[TB] FAIL press_irq_clear: got %b expected 0", kpd_irq);
    end
    readReg(1'b0, d);
    nChecks++;
    if (d !== 32'h90) begin
      nFails++; $display("[TB] FAIL press_status2: got %h expected %h", d, 32'h90);
    end
    waitCycles(48);
    nChecks++;
    if (kpd_irq !== 1'b0) begin
      nFails++; $display("[TB] FAIL hold_one_event: irq got %b expected 0", kpd_irq);
    end
    keys = 16'h0;
    waitCycles(64);
    readReg(1'b1, d);
    nChecks++;
    if (d !== 32'h0) begin
      nFails++; $display("[TB] FAIL release_raw: got %h expected 0", d);
    end
  endtask

  task automatic test_bounce;
    logic sawIrq;
    logic [31:0] d;
    sawIrq = 1'b0;
    for (int f = 0; f < 10; f++) begin
      keys = f[0] ? 16'h0000 : 16'h0020;
      for (int c = 0; c < 16; c++) begin
        @(negedge kpd_clk);
        if (kpd_irq !== 1'b0) sawIrq = 1'b1;
      end
    end
    keys = 16'h0;
    nChecks++;
    if (sawIrq !== 1'b0) begin
      nFails++; $display("[TB] FAIL bounce_irq: irq seen %b expected 0", sawIrq);
    end
    readReg(1'b1, d);
    nChecks++;
    if (d !== 32'h0) begin
      nFails++; $display("[TB] FAIL bounce_raw: got %h expected 0", d);
    end
    waitCycles(48);
  endtask

  task automatic test_overflow;
    int cyc;
    logic [31:0] d;
    keys = 16'h0008;
    waitIrq(80, cyc);
    nChecks++;
    if (kpd_irq !== 1'b1) begin
      nFails++; $display("[TB] FAIL ovf_first_irq: got %b expected 1", kpd_irq);
    end
    keys = 16'h1008;
    waitCycles(60);
    readReg(1'b0, d);
    nChecks++;
    if (d !== 32'h33) begin
      nFails++; $display("[TB] FAIL ovf_status: got %h expected %h", d, 32'h33);
    end
    readReg(1'b0, d);
    nChecks++;
    if (d !== 32'h30) begin
      nFails++; $display("[TB] FAIL ovf_status2: got %h expected %h", d, 32'h30);
    end
    keys = 16'h0;
    waitCycles(64);
  endtask

  task automatic test_raw_multi;
    int cyc;
    logic [31:0] d;
    keys = 16'h8001;
    waitIrq(80, cyc);
    nChecks++;
    if (kpd_irq !== 1'b1) begin
      nFails++; $display("[TB] FAIL multi_irq: got %b expected 1", kpd_irq);
    end
    readReg(1'b1, d);
    nChecks++;
    if (d !== 32'h0000_8001) begin
      nFails++; $display("[TB] FAIL multi_raw: got %h expected %h", d, 32'h0000_8001);
    end
    readReg(1'b0, d);
    nChecks++;
    if (d !== 32'h01) begin
      nFails++; $display("[TB] FAIL multi_status: got %h expected %h", d, 32'h01);
    end
    keys = 16'h0;
    waitCycles(64);
  endtask

  task automatic test_collision;
    int cyc;
    int guard;
    logic [31:0] d;
    keys = 16'h0004;
    waitIrq(80, cyc);
    nChecks++;
    if (kpd_irq !== 1'b1) begin
      nFails++; $display("[TB] FAIL coll_first_irq: got %b expected 1", kpd_irq);
    end
    // Align to the negedge right after a frame boundary (column 3 -> column 0).
    guard = 0;
    while (kpd_col !== 4'b0111 && guard < 40) begin
      @(negedge kpd_clk); guard++;
    end
    while (kpd_col !== 4'b1110 && guard < 80) begin
      @(negedge kpd_clk); guard++;
    end
    nChecks++;
    if (kpd_col !== 4'b1110) begin
      nFails++; $display("[TB] FAIL coll_frame_align: col got %b expected %b", kpd_col, 4'b1110);
    end
    keys = 16'h0084;
    waitCycles(31);
    readReg(1'b0, d);
    nChecks++;
    if (d !== 32'h21) begin
      nFails++; $display("[TB] FAIL coll_status: got %h expected %h", d, 32'h21);
    end
    nChecks++;
    if (kpd_irq !== 1'b1) begin
      nFails++; $display("[TB] FAIL coll_irq: got %b expected 1", kpd_irq);
    end
    readReg(1'b0, d);
    nChecks++;
    if (d !== 32'h71) begin
      nFails++; $display("[TB] FAIL coll_status2: got %h expected %h", d, 32'h71);
    end
    keys = 16'h0;
    waitCycles(64);
    readReg(1'b1, d);
    nChecks++;
    if (d !== 32'h0) begin
      nFails++; $display("[TB] FAIL coll_release_raw: got %h expected 0", d);
    end
  endtask

  task automatic test_reset;
    int cyc;
    logic [31:0] d;
    keys = 16'h0010;
    waitIrq(80, cyc);
    nChecks++;
    if (kpd_irq !== 1'b1) begin
      nFails++; $display("[TB] FAIL rst_pre_irq: got %b expected 1", kpd_irq);
    end
    waitCycles(6);
    kpd_rst = 1'b1;
    @(negedge kpd_clk);
    kpd_rst = 1'b0;
    nChecks++;
    if (kpd_col !== 4'b1110) begin
      nFails++; $display("[TB] FAIL rst_col: got %b expected %b", kpd_col, 4'b1110);
    end
    nChecks++;
    if (kpd_irq !== 1'b0) begin
      nFails++; $display("[TB] FAIL rst_irq: got %b expected 0", kpd_irq);
    end
    nChecks++;
    if (kpd_rdata !== 32'h0) begin
      nFails++; $display("[TB] FAIL rst_rdata: got %h expected 0", kpd_rdata);
    end
    readReg(1'b0, d);
    nChecks++;
    if (d !== 32'h0) begin
      nFails++; $display("[TB] FAIL rst_status: got %h expected 0", d);
    end
    keys = 16'h0;
  endtask

  initial begin
    keys     = 16'h0;
    kpd_addr = 32'h0;
    kpd_re   = 1'b0;
    kpd_rst  = 1'b1;
    @(negedge kpd_clk);
    test_reset_values();
    test_single_press();
    test_bounce();
    test_overflow();
    test_raw_multi();
    test_collision();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/key_scan.md
# key_scan

Memory-mapped 4x4 matrix keypad scanner: the input-side counterpart of the multiplexed seven-segment display driver on the board I/O bus. It drives one keypad column low at a time, samples the rows, and debounces whole scan frames. It latches the first new key press as an event the CPU reads and pops over the same addr/data bus style used by the display.

## Interface
- FREQ, 100: column dwell length; each column is driven for FREQ+1 clocks. Legal range is 3..65535.
- DEBOUNCE, 2: number of consecutive identical frames required before the debounced map updates. Legal range is 1..15.

- kpd_clk  in  1  system clock; the block uses this single clock for all logic.
- kpd_rst  in  1  synchronous, active-high reset.
- kpd_col  out  4  column drive, active-low; exactly one bit is low at any time.
- kpd_row  in  4  row sense, active-low (pulled up); asynchronous to kpd_clk.
- kpd_addr  in  32  bus address; only bit 2 is decoded.
- kpd_re  in  1  read strobe, one cycle per read.
- kpd_rdata  out  32  read data, registered.
- kpd_irq  out  1  level output equal to STATUS.valid.

## Operation
- **Row input:** kpd_row passes through a 2-flop synchronizer before use.
- **Scan counters:** column index idx is 2 bits; the dwell counter cnt is 16 bits and counts down from FREQ.
  - kpd_col = ~(4'b1 << idx).
  - When cnt==0, the synchronized rows are sampled and the block does: frame[idx*4 +: 4] <= ~rows_sync, then idx <= idx+1 (wrapping 3->0), then cnt <= FREQ.
  - Otherwise cnt decrements.
- **Key numbering:** bit k of frame means key k is pressed, with k = col*4 + row.
- **Frame complete:** a frame completes on the cnt==0 sample with idx==3. The comparison uses the fully assembled frame, including the column-3 nibble sampled on that edge.
  - If the new frame equals the previous frame, stable increments, saturating at 15. Otherwise stable <= 0.
  - When the new frame equals the previous frame and stable+1 >= DEBOUNCE-1, the debounced map deb[15:0] <= frame.
  - With DEBOUNCE=1, deb follows every completed frame.
- **Press event:** new = frame & ~deb, evaluated only on the edge where deb updates. If new is nonzero, the event code is the lowest set index of new.
  - If valid==0: code <= index and valid <= 1.
  - If valid==1: ovf <= 1 and code is kept (the oldest event wins).
- **Register map** (kpd_addr[2]):
  - 0 = STATUS: bit0 valid, bit1 ovf, bits7:4 code, all other bits 0.
  - 1 = RAW: bits15:0 deb, bits31:16 0.
- **Reads:** on a cycle with kpd_re=1, kpd_rdata <= the selected register. A STATUS read also clears valid and ovf on the same edge.
  - A RAW read has no side effects.
  - kpd_rdata holds its value when kpd_re=0.
- **Read colliding with an event** (STATUS read on the same edge as an event): the read returns the pre-edge contents. The new event is then latched with valid=1 and code=new index, and ovf is set to 0 (the read consumed the old event).
- **Reset:** kpd_rst cancels any scan in progress and takes effect on the next edge.

## Timing
- **Reset values:**
  - kpd_col=4'b1110, kpd_rdata=0, kpd_irq=0.
  - idx=0, cnt=FREQ.
  - frame, prev, deb, stable, code, valid, ovf, and the synchronizer are all 0.
- **Scan period:** one column lasts FREQ+1 cycles; one frame lasts 4*(FREQ+1) cycles.
- **Sampling:** a sample reflects the row state at least 2 cycles earlier, so rows settle for at least FREQ-2 cycles after a column switch.
- **Press-to-event latency:** at most (DEBOUNCE+1) frames plus 2 cycles.
- **Read latency:** kpd_rdata is valid 1 cycle after kpd_re. kpd_irq falls on the same edge that loads kpd_rdata.
- **Key release:** clears the bit in deb after DEBOUNCE stable frames and generates no event.
- **Holding a key:** produces exactly one event.

## Test plan
All scenarios use FREQ=3 and DEBOUNCE=2 (frame = 16 cycles).
1. **Reset state:** assert kpd_rst for 1 cycle mid-scan with valid=1. Next cycle kpd_col=4'b1110 and kpd_irq=0; a STATUS read returns 0x0.
2. **Single press:** hold key 9 (col 2, row 1 low while kpd_col[2]=0).
   - Within 3 frames + 2 cycles, kpd_irq=1 and STATUS reads 0x91.
   - The following STATUS read returns 0x90 and kpd_irq=0.
3. **Bounce rejection:** toggle key 5 every frame for 10 frames. kpd_irq stays 0 and RAW reads 0x0.
4. **Overflow:** press key 3, then press key 12 with no read in between.
   - STATUS reads 0x33 (valid, ovf, code 3).
   - The next STATUS read returns 0x30.
5. **RAW multi-key:** hold keys 0 and 15. RAW reads 0x00008001; STATUS code is 0 (lowest index wins).
6. **Read/event collision:** issue a STATUS read on the same edge deb gains key 7 while valid=1 with code 2.
   - The read returns 0x21.
   - The next STATUS read returns 0x71.
